// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision constants and flag bit positions.
// Flag vector layout: {nan, inf, zero, ovf, udf}.
package ieee754_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int unsigned FLAG_W = 5;
  localparam int unsigned NAN    = 4;
  localparam int unsigned INF    = 3;
  localparam int unsigned ZERO   = 2;
  localparam int unsigned OVF    = 1;
  localparam int unsigned UDF    = 0;

endpackage

// File: rtl/ieee754_classify.sv
// Combinational classification and optional flush-to-zero of a multiplier result.
// Ports:
//   word    - raw single-precision result
//   mul_ovf - multiplier overflow flag
//   mul_udf - multiplier underflow flag
//   result  - word after flushing (unchanged unless FTZ flushes a subnormal)
//   flags   - {nan, inf, zero, ovf, udf}
module ieee754_classify
  import ieee754_pkg::*;
#(
  parameter int unsigned FTZ = 1
) (
  input  logic [31:0]       word,
  input  logic              mul_ovf,
  input  logic              mul_udf,
  output logic [31:0]       result,
  output logic [FLAG_W-1:0] flags
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;
  logic             subnormal;
  logic             flush;

  assign exp_field = word[30:23];
  assign man_field = word[22:0];
  assign subnormal = (exp_field == '0) && (man_field != '0);
  assign flush     = (FTZ != 0) && subnormal;

  always_comb begin
    result      = flush ? {word[31], 31'b0} : word;
    flags       = '0;
    flags[NAN]  = (exp_field == EXP_MAX) && (man_field != '0);
    flags[INF]  = (exp_field == EXP_MAX) && (man_field == '0);
    // Zero is judged on the flushed word so a flushed subnormal reads as zero.
    flags[ZERO] = (result[30:0] == '0);
    flags[OVF]  = mul_ovf || flags[INF];
    flags[UDF]  = mul_udf || flush;
  end

endmodule

// File: rtl/ieee754_result_queue.sv
// Result queue for ieee754_mul: classifies each pushed result, stores word plus flags in a
// DEPTH-entry FIFO and accumulates sticky flags.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid/in_ready           - push handshake; in_s, in_ovf, in_udf are the payload
//   out_valid/out_ready         - pop handshake; out_data, out_flags are the head entry
//   sticky_flags, clr_sticky    - OR of accepted flags, synchronous clear
//   count                       - number of occupied entries
module ieee754_result_queue
  import ieee754_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FTZ   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_s,
  input  logic                       in_ovf,
  input  logic                       in_udf,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [FLAG_W-1:0]          sticky_flags,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       data_mem [DEPTH];
  logic [FLAG_W-1:0] flag_mem [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  logic [31:0]       cls_word;
  logic [FLAG_W-1:0] cls_flags;
  logic              push;
  logic              pop;

  ieee754_classify #(
    .FTZ (FTZ)
  ) u_classify (
    .word    (in_s),
    .mul_ovf (in_ovf),
    .mul_udf (in_udf),
    .result  (cls_word),
    .flags   (cls_flags)
  );

  // Handshakes depend on registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    // Power-of-two DEPTH: pointer overflow is the modulo wrap.
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A push in the same cycle as a clear wins over the clear.
    if (push) begin
      sticky_d = clr_sticky ? cls_flags : (sticky_q | cls_flags);
    end else if (clr_sticky) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is not reset; empty-queue outputs are masked below instead.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr_q] <= cls_word;
      flag_mem[wptr_q] <= cls_flags;
    end
  end

  assign out_data     = out_valid ? data_mem[rptr_q] : '0;
  assign out_flags    = out_valid ? flag_mem[rptr_q] : '0;
  assign sticky_flags = sticky_q;
  assign count        = count_q;

endmodule

// File: doc/ieee754_result_queue.md
IEEE754_RESULT_QUEUE -- requirements
Module: ieee754_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter FTZ, default 1; when 1, subnormal results are flushed to signed zero.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  means the multiplier result on in_s, in_ovf and in_udf is valid.
REQ-006 Port in_s  input  32  is the IEEE-754 single-precision result from ieee754_mul.
REQ-007 Ports in_ovf and in_udf, input, 1 bit each, carry the multiplier's overflow and underflow flags.
REQ-008 Port in_ready  output  1  means the queue SHALL accept an entry this cycle.
REQ-009 Port out_valid  output  1  means the head entry is presented.
REQ-010 Port out_ready  input  1  means the consumer takes the head entry.
REQ-011 Port out_data  output  32  is the head result word.
REQ-012 Port out_flags  output  5  is the head flags, ordered {nan, inf, zero, ovf, udf}.
REQ-013 Port sticky_flags  output  5  is the OR of flags over all accepted entries since the last clear.
REQ-014 Port clr_sticky  input  1  is a synchronous clear of sticky_flags.
REQ-015 Port count  output  clog2(DEPTH)+1  is the number of occupied entries.

Function
REQ-016 A push SHALL occur on a rising edge when in_valid and in_ready are both 1; a pop SHALL occur on a rising edge when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL be (count != DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be (count != 0); out_data and out_flags SHALL come from the entry at the read pointer.
REQ-019 Latency: an entry pushed into an empty queue SHALL appear on out_valid/out_data in the next cycle; there is no same-cycle bypass.
REQ-020 Classification SHALL be done at push time, on exponent e = in_s[30:23] and mantissa m = in_s[22:0]:
- nan = (e == 8'hFF) and (m != 0)
- inf = (e == 8'hFF) and (m == 0)
- zero = (e == 0) and (m == 0), evaluated after flushing
- ovf = in_ovf OR inf
- udf = in_udf OR (a flush occurred)
REQ-021 With FTZ = 1 and e == 0, m != 0, the block SHALL store {in_s[31], 31'b0} and set both zero and udf; with FTZ = 0 it SHALL store in_s unchanged.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and is legal at any count from 1 to DEPTH-1; at count == DEPTH only the pop occurs.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or drop below 0.
REQ-024 A pop attempted while empty, or a push attempted while full, SHALL be ignored with no state change.
REQ-025 On each push, sticky_flags SHALL take sticky_flags OR the pushed flags.
REQ-026 If clr_sticky and a push occur in the same cycle, sticky_flags SHALL equal the pushed flags (the new event wins).

Reset
REQ-027 While rst_n = 0, the block SHALL clear count, both pointers and sticky_flags immediately and asynchronously; out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-028 After reset, out_data and out_flags SHALL be 0; storage contents need not be cleared.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries; the first push after rst_n deasserts SHALL be the first entry popped.

Structure
REQ-030 The flag bit indices (NAN = 4, INF = 3, ZERO = 2, OVF = 1, UDF = 0) and the constants EXP_MAX = 8'hFF, EXP_W = 8 and MAN_W = 23 SHALL live in the shared package ieee754_pkg.
REQ-031 Classification and flushing SHALL be a combinational sub-module, ieee754_classify (32-bit input; 32-bit output plus 5 flags); the queue storage and pointers SHALL stay in the top module.

Verification
REQ-032 Push 0x41400000 (3.0 × 4.0) with in_ovf = 0, in_udf = 0 into an empty queue -> the next cycle shows out_valid = 1, out_data = 0x41400000, out_flags = 5'b00000, count = 1.
REQ-033 Push 0x7F800000 with in_ovf = 1 -> out_flags = 5'b01010 and sticky_flags = 5'b01010; then push 0x7FC00000 -> that entry has flags 5'b10000 and sticky_flags = 5'b11010.
REQ-034 Push 0x00400000 with FTZ = 1 -> out_data = 0x00000000 and out_flags = 5'b00101; push 0x80000000 -> flags 5'b00100.
REQ-035 Push 5 entries with out_ready = 0 -> count = 4 and in_ready = 0, the 5th is not accepted, and popping then returns the first 4 in order.
REQ-036 At count = 2, push and pop in the same cycle -> count stays 2 and the FIFO order is preserved across pointer wrap (run 10 cycles).
REQ-037 Pulse rst_n = 0 with 3 entries queued -> count = 0, out_valid = 0 and sticky_flags = 0 immediately, with no clock edge needed.
